// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration helpers for the serial sequence detectors.
// Holds the legal pattern-length range and the width rule for the fill counter.
package seq_det_pkg;

  localparam int N_MIN = 2;
  localparam int N_MAX = 16;

  // fill runs 0..n inclusive, so it needs room for n+1 distinct values
  function automatic int fill_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic bit n_legal(input int n);
    return (n >= N_MIN) && (n <= N_MAX);
  endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
// Shared by the detector family for match statistics.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // count register: clear, then saturating increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= CNT_ZERO;
    end else if (clr) begin
      cnt <= CNT_ZERO;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Programmable N-bit serial pattern detector with don't-care mask, overlap control,
// optional registered match output and a saturating match counter.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int           N           = 4,
  parameter logic [N-1:0] RST_PATTERN = 4'b1010,
  parameter logic [N-1:0] RST_MASK    = {N{1'b1}},
  parameter bit           OVERLAP     = 1'b1,
  parameter bit           REG_OUT     = 1'b0,
  parameter int           CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             cfg_we,
  input  logic [N-1:0]     cfg_pattern,
  input  logic [N-1:0]     cfg_mask,
  input  logic             cnt_clr,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int             FW        = fill_width(N);
  localparam logic [FW-1:0]  FILL_ZERO = {FW{1'b0}};
  localparam logic [FW-1:0]  FILL_ONE  = {{(FW-1){1'b0}}, 1'b1};
  localparam logic [FW-1:0]  FILL_FULL = FW'(N);
  localparam logic [FW-1:0]  FILL_ARM  = FW'(N - 1);
  localparam logic [N-1:0]   VEC_ZERO  = {N{1'b0}};

  if (!n_legal(N)) begin : g_bad_n
    $error("seq_detect_param: N=%0d outside %0d..%0d", N, N_MIN, N_MAX);
  end

  logic [N-1:0]  hist_r;
  logic [FW-1:0] fill_r;
  logic [N-1:0]  pat_r;
  logic [N-1:0]  msk_r;
  logic [N-1:0]  cand_s;
  logic          accept_s;
  logic          hit_s;

  // candidate window and masked compare; a config write suppresses the bit entirely
  always_comb begin
    cand_s   = {hist_r[N-2:0], din};
    accept_s = din_valid & ~cfg_we;
    hit_s    = 1'b0;
    if (accept_s && (fill_r >= FILL_ARM)) begin
      hit_s = (((cand_s ^ pat_r) & msk_r) == VEC_ZERO);
    end else begin
      hit_s = 1'b0;
    end
  end

  // history, fill level and programmable pattern/mask
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_r <= VEC_ZERO;
      fill_r <= FILL_ZERO;
      pat_r  <= RST_PATTERN;
      msk_r  <= RST_MASK;
    end else if (cfg_we) begin
      hist_r <= VEC_ZERO;
      fill_r <= FILL_ZERO;
      pat_r  <= cfg_pattern;
      msk_r  <= cfg_mask;
    end else if (accept_s) begin
      hist_r <= cand_s;
      if (hit_s && !OVERLAP) begin
        fill_r <= FILL_ZERO;
      end else if (fill_r != FILL_FULL) begin
        fill_r <= fill_r + FILL_ONE;
      end else begin
        fill_r <= fill_r;
      end
    end else begin
      hist_r <= hist_r;
      fill_r <= fill_r;
    end
  end

  if (REG_OUT) begin : g_reg_out
    logic dout_r;

    // one-cycle delayed match pulse
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_r <= 1'b0;
      end else begin
        dout_r <= hit_s;
      end
    end

    assign dout = dout_r;
  end else begin : g_mealy_out
    assign dout = hit_s;
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit_s),
    .clr   (cnt_clr),
    .cnt   (match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench: four detector variants share one stimulus stream; expected pulses
// are hand-computed per step and counts are accumulated from those expectations.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic       din_valid;
  logic       cfg_we;
  logic [3:0] cfg_pattern;
  logic [3:0] cfg_mask;
  logic       cnt_clr;

  logic       dout_a, dout_b, dout_c, dout_d;
  logic [7:0] cnt_a, cnt_b, cnt_c;
  logic [1:0] cnt_d;

  int passed = 0;
  int total  = 0;
  int exp_a = 0, exp_b = 0, exp_c = 0, exp_d = 0;

  always #5 clk = ~clk;

  // A: defaults (overlap, Mealy)
  seq_detect_param u_a (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cnt_clr(cnt_clr),
    .dout(dout_a), .match_cnt(cnt_a));

  // B: non-overlap, Mealy
  seq_detect_param #(.OVERLAP(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cnt_clr(cnt_clr),
    .dout(dout_b), .match_cnt(cnt_b));

  // C: non-overlap, registered output
  seq_detect_param #(.OVERLAP(1'b0), .REG_OUT(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cnt_clr(cnt_clr),
    .dout(dout_c), .match_cnt(cnt_c));

  // D: overlap, Mealy, 2-bit counter
  seq_detect_param #(.CNT_W(2)) u_d (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cnt_clr(cnt_clr),
    .dout(dout_d), .match_cnt(cnt_d));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_all(input logic ea, input logic eb, input logic ec);
    chk("dout_a", {31'd0, dout_a}, {31'd0, ea});
    chk("dout_b", {31'd0, dout_b}, {31'd0, eb});
    chk("dout_c", {31'd0, dout_c}, {31'd0, ec});
    chk("dout_d", {31'd0, dout_d}, {31'd0, ea});
    chk("cnt_a", {24'd0, cnt_a}, exp_a);
    chk("cnt_b", {24'd0, cnt_b}, exp_b);
    chk("cnt_c", {24'd0, cnt_c}, exp_c);
    chk("cnt_d", {30'd0, cnt_d}, exp_d);
  endtask

  // ea: hit of overlap variants, eb: hit of non-overlap variants, ec: registered dout of C
  task automatic step(input logic d, input logic v, input logic clr,
                      input logic ea, input logic eb, input logic ec);
    @(posedge clk); #1;
    din = d; din_valid = v; cnt_clr = clr; cfg_we = 1'b0;
    @(negedge clk);
    chk_all(ea, eb, ec);
    if (clr) begin
      exp_a = 0; exp_b = 0; exp_c = 0; exp_d = 0;
    end else begin
      exp_a += int'(ea);
      exp_b += int'(eb);
      exp_c += int'(eb);
      if (ea && exp_d != 3) exp_d++;
    end
  endtask

  task automatic cfg(input logic [3:0] p, input logic [3:0] m, input logic ec);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_pattern = p; cfg_mask = m;
    din = 1'b1; din_valid = 1'b1; cnt_clr = 1'b0;
    @(negedge clk);
    chk_all(1'b0, 1'b0, ec);
  endtask

  initial begin
    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; cfg_we = 1'b0;
    cfg_pattern = 4'b0000; cfg_mask = 4'b0000; cnt_clr = 1'b0;
    #12;
    chk_all(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1010... stream: overlap hits on 4,6,8; non-overlap on 4,8; C one later
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // gap of three invalid cycles inside 1010 (ignored din is 1)
    cfg(4'b1010, 4'b1111, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // partial 0,1 then reprogram to 0110/1011; streams 0110 and 0010 both match
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cfg(4'b0110, 4'b1011, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // all-ones pattern: back-to-back overlap hits, clear coincident with a hit
    cfg(4'b1111, 4'b1111, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // reset after 101 with the closing 0 already on din: must clear without a clock
    cfg(4'b1010, 4'b1111, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0; din = 1'b0; din_valid = 1'b1;
    #1;
    exp_a = 0; exp_b = 0; exp_c = 0; exp_d = 0;
    chk_all(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_all(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
